reg_cfg_seq: RTL and testbench

Parametrised register-configuration sequencer for the HDMI transmitter. It walks a table of {register address, register data} pairs and issues one write per entry to the I2C master through a request/ready/done handshake. It adds three things the fixed lookup table lacks: NACK retry, delay entries, and restart on demand (e.g. hot-plug). It sits between the top-level init/HPD logic and the I2C master.

---
 rtl/hdmi_cfg_pkg.sv | 32 +++
 rtl/reg_cfg_seq_if.sv | 34 +++
 rtl/reg_cfg_rom.sv | 59 +++++
 rtl/reg_cfg_seq.sv | 160 ++++++++++++++++
 tb/tb_reg_cfg_seq.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdmi_cfg_pkg.sv
// ----------------------------------------------------------------------------
// hdmi_cfg_pkg
// Types and constants shared by the HDMI transmitter configuration path:
//   - seq_state_e        : state encoding of the register-configuration sequencer
//   - DELAY_MARK_DEFAULT : register-address value that tags a delay entry
//   - REG_ADDR_W / REG_DATA_W / ENTRY_W : widths of one {reg_addr, reg_data} pair
//   - pack_entry()       : builds one table pair from an address and a data byte
// ----------------------------------------------------------------------------
package hdmi_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_DELAY,
        ST_DONE,
        ST_ERROR
    } seq_state_e;

    localparam logic [7:0] DELAY_MARK_DEFAULT = 8'hFF;

    localparam int REG_ADDR_W = 8;
    localparam int REG_DATA_W = 8;
    localparam int ENTRY_W    = REG_ADDR_W + REG_DATA_W;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [REG_ADDR_W-1:0] reg_addr,
                                                      input logic [REG_DATA_W-1:0] reg_data);
        return {reg_addr, reg_data};
    endfunction

endpackage

// File: rtl/reg_cfg_seq_if.sv
// ----------------------------------------------------------------------------
// reg_cfg_seq_if
// Write-request channel between the configuration sequencer and the I2C master.
//   wr_req   : write request (sequencer -> master)
//   wr_ready : master accepts when wr_req && wr_ready
//   wr_dev   : 7-bit I2C device address
//   wr_reg   : register address
//   wr_data  : register data
//   wr_done  : one-cycle pulse at the end of a transfer (master -> sequencer)
//   wr_ack   : qualified by wr_done; 1 = ACK, 0 = NACK
// Modports: master = request side (sequencer), slave = I2C master side.
// ----------------------------------------------------------------------------
interface reg_cfg_seq_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              wr_req;
    logic              wr_ready;
    logic [6:0]        wr_dev;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;
    logic              wr_ack;

    modport master (
        output wr_req, wr_dev, wr_reg, wr_data,
        input  wr_ready, wr_done, wr_ack
    );

    modport slave (
        input  wr_req, wr_dev, wr_reg, wr_data,
        output wr_ready, wr_done, wr_ack
    );
endinterface

// File: rtl/reg_cfg_rom.sv
// ----------------------------------------------------------------------------
// reg_cfg_rom
// Combinational {reg_addr, reg_data} pair table holding the ADV7513 video
// configuration. Feeds the sequencer's tbl_idx / tbl_entry port pair.
//   idx   in  IDX_W   : table index
//   entry out ENTRY_W : {reg_addr, reg_data} for idx
// Indices past the populated table return a zero-length delay entry, which the
// sequencer treats as a no-op, so NUM_ENTRIES can be raised safely.
// ----------------------------------------------------------------------------
module reg_cfg_rom
    import hdmi_cfg_pkg::*;
#(
    parameter int NUM_ENTRIES = 31,
    localparam int IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic [IDX_W-1:0]   idx,
    output logic [ENTRY_W-1:0] entry
);

    always_comb begin
        // NOTE: default assignment first so every path drives entry; no latch.
        entry = pack_entry(DELAY_MARK_DEFAULT, 8'h00);
        case (int'(idx))
            0:  entry = pack_entry(8'h41, 8'h10);          // power up
            1:  entry = pack_entry(DELAY_MARK_DEFAULT, 8'h0A); // settle after power-up
            2:  entry = pack_entry(8'h98, 8'h03);          // fixed registers
            3:  entry = pack_entry(8'h9A, 8'hE0);
            4:  entry = pack_entry(8'h9C, 8'h30);
            5:  entry = pack_entry(8'h9D, 8'h61);
            6:  entry = pack_entry(8'hA2, 8'hA4);
            7:  entry = pack_entry(8'hA3, 8'hA4);
            8:  entry = pack_entry(8'hE0, 8'hD0);
            9:  entry = pack_entry(8'hF9, 8'h00);
            10: entry = pack_entry(8'h15, 8'h00);          // input ID: 24-bit RGB 4:4:4
            11: entry = pack_entry(8'h16, 8'h30);          // 8 bit per colour, style 1
            12: entry = pack_entry(8'h17, 8'h02);          // 16:9 aspect
            13: entry = pack_entry(8'h18, 8'h46);          // CSC disabled
            14: entry = pack_entry(8'hAF, 8'h06);          // HDMI mode
            15: entry = pack_entry(8'h40, 8'h80);          // general control packet on
            16: entry = pack_entry(8'h4C, 8'h04);          // 24-bit colour depth
            17: entry = pack_entry(8'hD6, 8'hC0);          // HPD forced high
            18: entry = pack_entry(8'h55, 8'h12);          // AVI infoframe: RGB
            19: entry = pack_entry(8'h56, 8'h28);          // AVI infoframe: 16:9
            20: entry = pack_entry(8'h3B, 8'h80);          // pixel repetition manual
            21: entry = pack_entry(8'h3C, 8'h00);          // VIC auto
            22: entry = pack_entry(8'hBA, 8'h60);          // input clock delay
            23: entry = pack_entry(8'hD0, 8'h3C);
            24: entry = pack_entry(8'hDE, 8'h9C);          // TMDS clock fix
            25: entry = pack_entry(8'hE4, 8'h60);
            26: entry = pack_entry(8'hFA, 8'h7D);
            27: entry = pack_entry(8'h0A, 8'h01);          // audio: I2S
            28: entry = pack_entry(8'h0B, 8'h0E);
            29: entry = pack_entry(8'h0C, 8'hBC);
            30: entry = pack_entry(8'h94, 8'hC0);          // HPD / monitor-sense interrupts
            default: ;
        endcase
    end

endmodule

// File: rtl/reg_cfg_seq.sv
// ----------------------------------------------------------------------------
// reg_cfg_seq
// Walks a {reg_addr, reg_data} table and issues one I2C write per entry, with
// NACK retry, delay entries (reg_addr == DELAY_MARK) and restart on start.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : pulse; (re)starts the sequence at index 0 from IDLE/DONE/ERROR
//   tbl_idx    : index of the table entry being read
//   tbl_entry  : {reg_addr, reg_data} for tbl_idx (combinational table)
//   bus        : write channel to the I2C master (request side)
//   busy       : sequence in progress
//   done       : every entry written; held until the next start
//   error      : retries exhausted; held until the next start
//   err_idx    : index of the entry that failed
// ----------------------------------------------------------------------------
module reg_cfg_seq
    import hdmi_cfg_pkg::*;
#(
    parameter int                NUM_ENTRIES = 31,
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter logic [6:0]        DEV_ADDR    = 7'h39,
    parameter int                MAX_RETRY   = 3,
    parameter logic [ADDR_W-1:0] DELAY_MARK  = ADDR_W'(DELAY_MARK_DEFAULT),
    parameter int                DELAY_UNIT  = 1000,
    localparam int               IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [IDX_W-1:0]         tbl_idx,
    input  logic [ADDR_W+DATA_W-1:0] tbl_entry,
    reg_cfg_seq_if.master            bus,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [IDX_W-1:0]         err_idx
);

    // The counter must hold (2^DATA_W - 1) * DELAY_UNIT - 1.
    localparam longint DLY_SPAN = (longint'(1) << DATA_W) * longint'(DELAY_UNIT);
    localparam int     CNT_W    = (DLY_SPAN > 2) ? $clog2(DLY_SPAN) : 1;
    localparam int     RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    seq_state_e        state;
    logic [RTY_W-1:0]  retry;
    logic [CNT_W-1:0]  dly_cnt;
    logic              wr_req_q;
    logic [ADDR_W-1:0] wr_reg_q;
    logic [DATA_W-1:0] wr_data_q;

    logic [ADDR_W-1:0] entry_addr;
    logic [DATA_W-1:0] entry_data;
    logic              last_entry;

    assign entry_addr = tbl_entry[ADDR_W+DATA_W-1:DATA_W];
    assign entry_data = tbl_entry[DATA_W-1:0];
    assign last_entry = (tbl_idx == IDX_W'(NUM_ENTRIES - 1));

    assign bus.wr_req  = wr_req_q;
    assign bus.wr_dev  = DEV_ADDR;
    assign bus.wr_reg  = wr_reg_q;
    assign bus.wr_data = wr_data_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge value of every other one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tbl_idx   <= '0;
            retry     <= '0;
            dly_cnt   <= '0;
            wr_req_q  <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_idx   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        tbl_idx <= '0;
                        retry   <= '0;
                        done    <= 1'b0;
                        error   <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    wr_reg_q  <= entry_addr;
                    wr_data_q <= entry_data;
                    if (entry_addr == DELAY_MARK) begin
                        // A zero count still spends one cycle in DELAY.
                        dly_cnt <= (entry_data == '0) ? '0
                                 : CNT_W'(entry_data) * CNT_W'(DELAY_UNIT) - CNT_W'(1);
                        state   <= ST_DELAY;
                    end else begin
                        wr_req_q <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end

                // A wr_done arriving here is deliberately not looked at.
                ST_ISSUE: begin
                    if (bus.wr_ready) begin
                        wr_req_q <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (bus.wr_done) begin
                        if (bus.wr_ack) begin
                            if (last_entry) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_DONE;
                            end else begin
                                tbl_idx <= tbl_idx + 1'b1;
                                retry   <= '0;
                                state   <= ST_FETCH;
                            end
                        end else if (retry < RTY_W'(MAX_RETRY)) begin
                            retry    <= retry + 1'b1;
                            wr_req_q <= 1'b1;
                            state    <= ST_ISSUE;
                        end else begin
                            err_idx <= tbl_idx;
                            error   <= 1'b1;
                            busy    <= 1'b0;
                            state   <= ST_ERROR;
                        end
                    end
                end

                ST_DELAY: begin
                    if (dly_cnt == '0) begin
                        if (last_entry) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_DONE;
                        end else begin
                            tbl_idx <= tbl_idx + 1'b1;
                            retry   <= '0;
                            state   <= ST_FETCH;
                        end
                    end else begin
                        dly_cnt <= dly_cnt - 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_cfg_seq.sv
// ----------------------------------------------------------------------------
// tb_reg_cfg_seq
// Directed bench for reg_cfg_seq on a 4-entry table with DELAY_UNIT = 10, plus
// a spot check of the production reg_cfg_rom contents. A small responder plays
// the I2C master: it logs each accepted write and answers with wr_done three
// negedges later, ACK unless a NACK budget is set for that table index.
// ----------------------------------------------------------------------------
module tb_reg_cfg_seq;
    import hdmi_cfg_pkg::*;

    localparam int N_ENT    = 4;
    localparam int IDX_W    = 2;
    localparam int RESP_LAT = 3;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [IDX_W-1:0]  tbl_idx;
    logic [15:0]       tbl_entry;
    logic              busy;
    logic              done;
    logic              error;
    logic [IDX_W-1:0]  err_idx;
    logic [15:0]       tbl [N_ENT];

    logic [4:0]         rom_idx;
    logic [ENTRY_W-1:0] rom_entry;

    int n_cmp = 0;
    int n_err = 0;

    // responder state and logs
    int         cyc = 0;
    int         pend = 0;
    logic       pend_ack = 1'b1;
    int         nack_left [N_ENT];
    int         issues [N_ENT];
    logic [7:0] acc_reg [$];
    logic [7:0] acc_data [$];
    int         acc_stamp [$];

    reg_cfg_seq_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    assign tbl_entry = tbl[tbl_idx];

    reg_cfg_seq #(
        .NUM_ENTRIES(N_ENT),
        .ADDR_W     (8),
        .DATA_W     (8),
        .DEV_ADDR   (7'h39),
        .MAX_RETRY  (3),
        .DELAY_MARK (8'hFF),
        .DELAY_UNIT (10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .tbl_idx  (tbl_idx),
        .tbl_entry(tbl_entry),
        .bus      (bus.master),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_idx  (err_idx)
    );

    reg_cfg_rom #(.NUM_ENTRIES(31)) rom (
        .idx  (rom_idx),
        .entry(rom_entry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // I2C master model
    initial begin
        bus.wr_done = 1'b0;
        bus.wr_ack  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.wr_done = 1'b0;
            bus.wr_ack  = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus.wr_done = 1'b1;
                        bus.wr_ack  = pend_ack;
                    end
                end
                if (bus.wr_req && bus.wr_ready) begin
                    acc_reg.push_back(bus.wr_reg);
                    acc_data.push_back(bus.wr_data);
                    acc_stamp.push_back(cyc);
                    issues[tbl_idx]++;
                    if (nack_left[tbl_idx] > 0) begin
                        nack_left[tbl_idx]--;
                        pend_ack = 1'b0;
                    end else begin
                        pend_ack = 1'b1;
                    end
                    pend = RESP_LAT;
                end
            end
        end
    end

    task automatic clear_logs();
        acc_reg.delete();
        acc_data.delete();
        acc_stamp.delete();
        for (int i = 0; i < N_ENT; i++) begin
            nack_left[i] = 0;
            issues[i]    = 0;
        end
    endtask

    task automatic load_basic();
        tbl[0] = 16'h11A1;
        tbl[1] = 16'h22B2;
        tbl[2] = 16'h33C3;
        tbl[3] = 16'h44D4;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_end(input int max_cyc, output bit busy_ok);
        int i;
        busy_ok = 1'b1;
        i = 0;
        do begin
            @(negedge clk);
            if (!busy && !(done || error)) busy_ok = 1'b0;
            i++;
        end while (!(done || error) && i < max_cyc);
        n_cmp++;
        if (!(done || error)) begin
            n_err++;
            $display("FAIL end_timeout: done/error still low after %0d cycles, required high", max_cyc);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (tbl_idx !== 2'd0)     begin n_err++; $display("FAIL rst_tbl_idx: got %0d want 0", tbl_idx); end
        n_cmp++; if (bus.wr_req !== 1'b0)  begin n_err++; $display("FAIL rst_wr_req: got %b want 0", bus.wr_req); end
        n_cmp++; if (busy !== 1'b0)        begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)        begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (error !== 1'b0)       begin n_err++; $display("FAIL rst_error: got %b want 0", error); end
        n_cmp++; if (bus.wr_reg !== 8'h00) begin n_err++; $display("FAIL rst_wr_reg: got %h want 00", bus.wr_reg); end
        n_cmp++; if (bus.wr_data !== 8'h00) begin n_err++; $display("FAIL rst_wr_data: got %h want 00", bus.wr_data); end
        n_cmp++; if (err_idx !== 2'd0)     begin n_err++; $display("FAIL rst_err_idx: got %0d want 0", err_idx); end
        n_cmp++; if (bus.wr_dev !== 7'h39) begin n_err++; $display("FAIL wr_dev: got %h want 39", bus.wr_dev); end
    endtask

    task automatic test_rom();
        rom_idx = 5'd0;  #1;
        n_cmp++; if (rom_entry !== 16'h4110) begin n_err++; $display("FAIL rom_0: got %h want 4110", rom_entry); end
        rom_idx = 5'd1;  #1;
        n_cmp++; if (rom_entry !== 16'hFF0A) begin n_err++; $display("FAIL rom_1: got %h want FF0A", rom_entry); end
        rom_idx = 5'd30; #1;
        n_cmp++; if (rom_entry !== 16'h94C0) begin n_err++; $display("FAIL rom_30: got %h want 94C0", rom_entry); end
    endtask

    task automatic test_basic();
        bit busy_ok;
        bit gap_ok;
        load_basic();
        clear_logs();
        pulse_start();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || bus.wr_req !== 1'b0) begin n_err++; $display("FAIL start_fetch: busy=%b wr_req=%b want 1/0", busy, bus.wr_req); end
        @(negedge clk);
        n_cmp++; if (bus.wr_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", bus.wr_req); end
        n_cmp++; if ({bus.wr_reg, bus.wr_data} !== 16'h11A1) begin n_err++; $display("FAIL first_pair: got %h want 11A1", {bus.wr_reg, bus.wr_data}); end
        wait_end(200, busy_ok);
        n_cmp++; if (acc_reg.size() != 4) begin n_err++; $display("FAIL basic_count: got %0d want 4", acc_reg.size()); end
        if (acc_reg.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if ({acc_reg[i], acc_data[i]} !== tbl[i]) begin
                    n_err++; $display("FAIL basic_write%0d: got %h want %h", i, {acc_reg[i], acc_data[i]}, tbl[i]);
                end
            end
            gap_ok = 1'b1;
            for (int i = 1; i < 4; i++) if (acc_stamp[i] - acc_stamp[i-1] != 5) gap_ok = 1'b0;
            n_cmp++; if (!gap_ok) begin n_err++; $display("FAIL basic_gap: issue spacing not 5 cycles (%0d,%0d,%0d,%0d)", acc_stamp[0], acc_stamp[1], acc_stamp[2], acc_stamp[3]); end
        end
        n_cmp++; if (done !== 1'b1 || error !== 1'b0) begin n_err++; $display("FAIL basic_end: done=%b error=%b want 1/0", done, error); end
        n_cmp++; if (!busy_ok) begin n_err++; $display("FAIL basic_busy: busy dropped before done, want held"); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_retry();
        bit busy_ok;
        load_basic();
        clear_logs();
        nack_left[2] = 2;
        pulse_start();
        wait_end(300, busy_ok);
        n_cmp++; if (issues[2] != 3) begin n_err++; $display("FAIL retry_issues: got %0d want 3", issues[2]); end
        n_cmp++; if (acc_reg.size() != 6) begin n_err++; $display("FAIL retry_count: got %0d want 6", acc_reg.size()); end
        if (acc_reg.size() == 6) begin
            n_cmp++; if (acc_stamp[3] - acc_stamp[2] != 4) begin n_err++; $display("FAIL retry_reissue_gap: got %0d want 4", acc_stamp[3] - acc_stamp[2]); end
            n_cmp++; if (acc_reg[3] !== 8'h33) begin n_err++; $display("FAIL retry_same_entry: got %h want 33", acc_reg[3]); end
        end
        n_cmp++; if (done !== 1'b1 || error !== 1'b0) begin n_err++; $display("FAIL retry_end: done=%b error=%b want 1/0", done, error); end
    endtask

    task automatic test_error();
        bit busy_ok;
        load_basic();
        clear_logs();
        nack_left[1] = 99;
        pulse_start();
        wait_end(300, busy_ok);
        n_cmp++; if (issues[1] != 4) begin n_err++; $display("FAIL err_issues: got %0d want 4", issues[1]); end
        n_cmp++; if (issues[2] != 0) begin n_err++; $display("FAIL err_no_entry2: got %0d want 0", issues[2]); end
        n_cmp++; if (error !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL err_flags: error=%b done=%b want 1/0", error, done); end
        n_cmp++; if (err_idx !== 2'd1) begin n_err++; $display("FAIL err_idx: got %0d want 1", err_idx); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL err_busy: got %b want 0", busy); end
    endtask

    task automatic test_delay();
        bit busy_ok;
        tbl[0] = 16'h10A0;
        tbl[1] = 16'hFF03;
        tbl[2] = 16'h20B0;
        tbl[3] = 16'h30C0;
        clear_logs();
        pulse_start();
        wait_end(300, busy_ok);
        n_cmp++; if (acc_reg.size() != 3) begin n_err++; $display("FAIL delay_count: got %0d want 3", acc_reg.size()); end
        if (acc_reg.size() == 3) begin
            n_cmp++; if (acc_reg[1] !== 8'h20) begin n_err++; $display("FAIL delay_next: got %h want 20", acc_reg[1]); end
            // 5-cycle write spacing + 1 extra fetch + 30 delay cycles
            n_cmp++; if (acc_stamp[1] - acc_stamp[0] != 36) begin n_err++; $display("FAIL delay_len: got %0d want 36", acc_stamp[1] - acc_stamp[0]); end
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL delay_done: got %b want 1", done); end
    endtask

    task automatic test_stall();
        bit busy_ok;
        bit stable_ok;
        int i;
        load_basic();
        clear_logs();
        @(posedge clk); #1 bus.wr_ready = 1'b0;
        pulse_start();
        i = 0;
        do begin @(negedge clk); i++; end while (!bus.wr_req && i < 20);
        n_cmp++; if (bus.wr_req !== 1'b1) begin n_err++; $display("FAIL stall_req: got %b want 1", bus.wr_req); end
        stable_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.wr_req !== 1'b1 || {bus.wr_reg, bus.wr_data} !== 16'h11A1) stable_ok = 1'b0;
        end
        n_cmp++; if (!stable_ok) begin n_err++; $display("FAIL stall_stable: req/reg/data moved while wr_ready low, want 1/11A1"); end
        n_cmp++; if (acc_reg.size() != 0) begin n_err++; $display("FAIL stall_no_accept: got %0d want 0", acc_reg.size()); end
        @(posedge clk); #1 bus.wr_ready = 1'b1;
        wait_end(200, busy_ok);
        n_cmp++; if (issues[0] != 1) begin n_err++; $display("FAIL stall_single: got %0d want 1", issues[0]); end
        n_cmp++; if (acc_reg.size() != 4) begin n_err++; $display("FAIL stall_count: got %0d want 4", acc_reg.size()); end
    endtask

    task automatic test_start_ignore_and_reset();
        bit busy_ok;
        int i;
        load_basic();
        clear_logs();
        pulse_start();
        i = 0;
        do begin @(negedge clk); i++; end while (!(tbl_idx == 2'd1 && bus.wr_req) && i < 50);
        n_cmp++; if (!(tbl_idx == 2'd1 && bus.wr_req)) begin n_err++; $display("FAIL ign_reach: idx=%0d req=%b want 1/1", tbl_idx, bus.wr_req); end
        // accepted on the next edge, start lands while in WAIT
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_cmp++; if (tbl_idx !== 2'd1 || busy !== 1'b1 || bus.wr_req !== 1'b0) begin
            n_err++; $display("FAIL ign_start: idx=%0d busy=%b req=%b want 1/1/0", tbl_idx, busy, bus.wr_req);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (tbl_idx !== 2'd0 || busy !== 1'b0 || bus.wr_req !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            n_err++; $display("FAIL midrst_flags: idx=%0d busy=%b req=%b done=%b err=%b want all 0", tbl_idx, busy, bus.wr_req, done, error);
        end
        n_cmp++; if ({bus.wr_reg, bus.wr_data} !== 16'h0000 || err_idx !== 2'd0) begin
            n_err++; $display("FAIL midrst_data: pair=%h err_idx=%0d want 0000/0", {bus.wr_reg, bus.wr_data}, err_idx);
        end
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_rst_idle: busy=%b want 0", busy); end
        clear_logs();
        pulse_start();
        wait_end(200, busy_ok);
        n_cmp++; if (acc_reg.size() != 4) begin n_err++; $display("FAIL rerun_count: got %0d want 4", acc_reg.size()); end
        if (acc_reg.size() == 4) begin
            n_cmp++; if ({acc_reg[0], acc_data[0]} !== 16'h11A1) begin n_err++; $display("FAIL rerun_first: got %h want 11A1", {acc_reg[0], acc_data[0]}); end
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rerun_done: got %b want 1", done); end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.wr_ready = 1'b1;
        rom_idx      = 5'd0;
        load_basic();
        clear_logs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        test_reset();
        test_rom();
        test_basic();
        test_retry();
        test_error();
        test_delay();
        test_stall();
        test_start_ignore_and_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
